cla_slice_sequencer: RTL and testbench
======================================

Name: cla_slice_sequencer

Overview:
- Multi-cycle N-bit adder controller.
- Holds one operand pair and pushes it through a single shared GS-bit carry-lookahead group, one slice per cycle, LSB slice first.
- The slice carry-out is registered and fed forward as the next slice's carry-in.
- Provides a ready/valid front end and back end, so one small lookahead group serves a wide add. Used wherever area matters more than add latency.

Parameters:
- N, 32, operand width; must be an integer multiple of GS.
- GS, 8, group (slice) width processed per cycle.
- NS, N/GS (localparam), number of slices per add.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept an operand pair
- a  input  N  operand A
- b  input  N  operand B
- cin  input  1  carry-in to bit 0
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  N  A+B+cin, modulo 2^N
- cout  output  1  carry-out of bit N-1
- outG  output  1  whole-word group generate
- outP  output  1  whole-word group propagate
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst_n low, asynchronous, any state, including mid-add):
  - state goes to IDLE and slice index to 0.
  - sum, cout, outG, outP and out_valid are 0; in_ready is 1; busy is 0.
  - Any partially processed add is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture a, b, cin into internal registers; clear sum; set carry reg = cin, Gacc=0, Pacc=1, idx=0; go to RUN.
- RUN:
  - in_ready=0.
  - Per cycle, on slice idx (bits idx*GS .. idx*GS+GS-1):
    - Bit level: g=a&b, p=a^b.
    - Lookahead chain: GI[1]=g[1]; GI[i]=g[i]|(p[i]&GI[i-1]). Slice G=GI[GS]; slice P=AND of all p.
    - Bit carries: c[0]=carry reg; c[i+1]=g[i]|(p[i]&c[i]). Slice sum bits = p^c.
  - Register updates at the clock edge:
    - sum slice is written.
    - carry reg <= G|(P&carry reg).
    - Gacc <= G|(P&Gacc).
    - Pacc <= Pacc&P.
    - idx <= idx+1.
  - When idx==NS-1: cout <= the new carry value, outG <= the new Gacc, outP <= the new Pacc; go to DONE and reset idx to 0.
- DONE:
  - out_valid=1; outputs are held stable while out_valid=1 and out_ready=0.
  - On out_ready: go to IDLE. out_valid drops the next cycle.
  - No new operand is accepted in the same cycle as the result handshake.
- Latency: the accept edge is edge k; out_valid rises after edge k+NS. Minimum initiation interval is NS+2 cycles.
- in_valid during RUN or DONE is ignored; the producer must hold it until in_ready.
- sum, cout, outG and outP keep their last values in IDLE; they are not cleared after a handshake.
- N==GS (NS=1) is legal: RUN lasts one cycle.
- Width rules:
  - idx is $clog2(NS) bits, minimum 1.
  - The result is modulo 2^N; overflow is reported only through cout (see the optional feature).
- outG/outP describe the N-bit word alone and are independent of cin.

Optional Feature:
- Macro: CLA_SEQ_OVF_EN.
- When defined:
  - Extra output port ovf (1 bit) = signed two's-complement overflow, i.e. carry into bit N-1 XOR cout.
  - Registered with cout. Reset value 0. Held like the other result outputs.
- When undefined: port ovf does not exist and no bit-N-1 carry-in register is built.

Test Plan (N=32, GS=8):
1. a=0x0000_0001, b=0x0000_0001, cin=0 -> sum=0x0000_0002, cout=0, outG=0, outP=0; out_valid high exactly 4 cycles after the accept edge.
2. a=0xFFFF_FFFF, b=0x0000_0000, cin=1 -> sum=0x0000_0000, cout=1, outG=0, outP=1 (carry rippled through all 4 slices).
3. a=0x8000_0000, b=0x8000_0000, cin=0 -> sum=0, cout=1, outG=1, outP=0; with CLA_SEQ_OVF_EN, ovf=1.
4. Back-pressure: out_ready=0 for 5 cycles after out_valid -> sum/cout/outG/outP stable and in_ready=0 throughout. Then out_ready=1 -> IDLE next cycle, and in_ready=1.
5. Assert rst_n low during RUN at idx=2 -> outputs 0 and in_ready=1 immediately (asynchronous). A new add of 0x1234_5678+0x1111_1111 then returns 0x2345_6789, cout=0.
6. 1000 random operand pairs with random cin and random in_valid/out_ready stalls -> each sum, cout, outG and outP matches the reference model; no accepts are dropped or duplicated.

Source files
------------

// File: rtl/cla_slice_sequencer.sv
// Multi-cycle N-bit adder: one shared GS-bit carry-lookahead group processes one slice per cycle.
// Optional signed-overflow output `ovf` is built when CLA_SEQ_OVF_EN is defined.
module cla_slice_sequencer #(
   parameter int N  = 32,
   parameter int GS = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] sum,
   output logic         cout,
   output logic         outG,
   output logic         outP,
   output logic         busy
`ifdef CLA_SEQ_OVF_EN
   ,
   output logic         ovf
`endif
);

   localparam int NS = N / GS;
   localparam int IW = (NS > 1) ? $clog2(NS) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state_q;
   logic [N-1:0]  a_q, b_q, sum_q;
   logic [IW-1:0] idx_q;
   logic          carry_q, gacc_q, pacc_q;
   logic          cout_q, outg_q, outp_q;
`ifdef CLA_SEQ_OVF_EN
   logic          ovf_q;
`endif

   int            base;
   logic [GS-1:0] sa, sb, sg, sp, sc, ss;
   logic          slice_g, slice_p, last;
   logic          carry_d, gacc_d, pacc_d;
   logic [N-1:0]  sum_d;

   // NOTE: every variable gets a value at the top of always_comb so no path leaves it unassigned (no latch).
   always_comb begin
      base = GS * int'(idx_q);
      sa   = a_q[base +: GS];
      sb   = b_q[base +: GS];
      sg   = sa & sb;
      sp   = sa ^ sb;

      slice_g = sg[0];
      for (int i = 1; i < GS; i++) slice_g = sg[i] | (sp[i] & slice_g);
      slice_p = &sp;

      sc[0] = carry_q;
      for (int i = 0; i < GS - 1; i++) sc[i+1] = sg[i] | (sp[i] & sc[i]);
      ss = sp ^ sc;

      carry_d = slice_g | (slice_p & carry_q);
      gacc_d  = slice_g | (slice_p & gacc_q);
      pacc_d  = pacc_q & slice_p;

      sum_d = sum_q;
      sum_d[base +: GS] = ss;

      last = (idx_q == IW'(NS - 1));
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: operand registers are reset too; the cost is small and the block never holds X.
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         gacc_q  <= 1'b0;
         pacc_q  <= 1'b1;
         cout_q  <= 1'b0;
         outg_q  <= 1'b0;
         outp_q  <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= a;
                  b_q     <= b;
                  carry_q <= cin;
                  gacc_q  <= 1'b0;
                  pacc_q  <= 1'b1;
                  idx_q   <= '0;
                  sum_q   <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               sum_q   <= sum_d;
               carry_q <= carry_d;
               gacc_q  <= gacc_d;
               pacc_q  <= pacc_d;
               if (last) begin
                  cout_q  <= carry_d;
                  outg_q  <= gacc_d;
                  outp_q  <= pacc_d;
`ifdef CLA_SEQ_OVF_EN
                  // Top slice: sc[GS-1] is the carry into bit N-1.
                  ovf_q   <= sc[GS-1] ^ carry_d;
`endif
                  idx_q   <= '0;
                  state_q <= DONE;
               end else begin
                  idx_q <= idx_q + IW'(1);
               end
            end
            DONE: begin
               if (out_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign outG      = outg_q;
   assign outP      = outp_q;
`ifdef CLA_SEQ_OVF_EN
   assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_cla_slice_sequencer.sv
// Directed and randomized bench for cla_slice_sequencer (N=32, GS=8).
// Covers the optional ovf output when CLA_SEQ_OVF_EN is defined.
module tb_cla_slice_sequencer;

   logic        clk, rst_n, in_valid, out_ready, cin;
   logic [31:0] a, b, sum;
   logic        in_ready, out_valid, cout, outG, outP, busy;
`ifdef CLA_SEQ_OVF_EN
   logic        ovf;
`endif

   int total, bad;

   cla_slice_sequencer #(.N(32), .GS(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .outG(outG), .outP(outP), .busy(busy)
`ifdef CLA_SEQ_OVF_EN
      , .ovf(ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({in_ready, out_valid, busy, cout, outG, outP} !== 6'b100000) begin
         bad++;
         $display("FAIL reset_ctrl: got %b expected 100000", {in_ready, out_valid, busy, cout, outG, outP});
      end
      total++;
      if (sum !== 32'h0) begin bad++; $display("FAIL reset_sum: got %h expected 00000000", sum); end
      rst_n = 1'b1;
      @(posedge clk); #1;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_vectors();
      logic [31:0] va[4]  = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
      logic [31:0] vb[4]  = '{32'h0000_0001, 32'h0000_0000, 32'h8000_0000, 32'h0000_0001};
      logic        vc[4]  = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic [31:0] vs[4]  = '{32'h0000_0002, 32'h0000_0000, 32'h0000_0000, 32'h8000_0000};
      logic [2:0]  vf[4]  = '{3'b000, 3'b101, 3'b110, 3'b000};
`ifdef CLA_SEQ_OVF_EN
      logic        vo[4]  = '{1'b0, 1'b0, 1'b1, 1'b1};
`endif
      int lat;
      for (int i = 0; i < 4; i++) begin
         a = va[i]; b = vb[i]; cin = vc[i]; in_valid = 1'b1;
         total++;
         if (in_ready !== 1'b1) begin bad++; $display("FAIL vec%0d_ready: got %b expected 1", i, in_ready); end
         @(posedge clk); #1;
         in_valid = 1'b0;
         lat = 0;
         while (out_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
         total++;
         if (lat !== 4) begin bad++; $display("FAIL vec%0d_latency: got %0d expected 4", i, lat); end
         total++;
         if (sum !== vs[i]) begin bad++; $display("FAIL vec%0d_sum: got %h expected %h", i, sum, vs[i]); end
         total++;
         if ({cout, outG, outP} !== vf[i]) begin
            bad++; $display("FAIL vec%0d_flags: got %b expected %b", i, {cout, outG, outP}, vf[i]);
         end
`ifdef CLA_SEQ_OVF_EN
         total++;
         if (ovf !== vo[i]) begin bad++; $display("FAIL vec%0d_ovf: got %b expected %b", i, ovf, vo[i]); end
`endif
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
         total++;
         if ({out_valid, in_ready, busy} !== 3'b010) begin
            bad++; $display("FAIL vec%0d_handshake: got %b expected 010", i, {out_valid, in_ready, busy});
         end
         total++;
         if (sum !== vs[i]) begin bad++; $display("FAIL vec%0d_hold: got %h expected %h", i, sum, vs[i]); end
      end
   endtask

   task automatic test_backpressure();
      int lat;
      a = 32'hFFFF_0000; b = 32'h0001_0000; cin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      a = 32'h0000_0003; b = 32'h0000_0004;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
      total++;
      if (lat !== 4) begin bad++; $display("FAIL bp_latency: got %0d expected 4", lat); end
      for (int i = 0; i < 5; i++) begin
         total++;
         if ({sum, cout, outG, outP, out_valid, in_ready, busy} !== {32'h0, 3'b110, 3'b101}) begin
            bad++;
            $display("FAIL bp_stall%0d: got %h/%b expected 00000000/110101", i, sum,
                     {cout, outG, outP, out_valid, in_ready, busy});
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      total++;
      if ({out_valid, in_ready, busy, cout} !== 4'b0101) begin
         bad++; $display("FAIL bp_release: got %b expected 0101", {out_valid, in_ready, busy, cout});
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
      total++;
      if ({sum, cout, outG, outP} !== {32'h0000_0007, 3'b000} || lat !== 4) begin
         bad++; $display("FAIL bp_next_add: got %h/%b lat=%0d expected 00000007/000 lat=4", sum, {cout, outG, outP}, lat);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_async_reset();
      int lat;
      a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      total++;
      if ({in_ready, out_valid, busy, cout, outG, outP} !== 6'b100000) begin
         bad++; $display("FAIL arst_ctrl: got %b expected 100000", {in_ready, out_valid, busy, cout, outG, outP});
      end
      total++;
      if (sum !== 32'h0) begin bad++; $display("FAIL arst_sum: got %h expected 00000000", sum); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
      total++;
      if ({sum, cout, outG, outP} !== {32'h2345_6789, 3'b000} || lat !== 4) begin
         bad++; $display("FAIL arst_readd: got %h/%b lat=%0d expected 23456789/000 lat=4", sum, {cout, outG, outP}, lat);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_random();
      logic [31:0] ra, rb;
      logic        rc, exp_p;
      logic [32:0] full, gen;
      logic [31:0] low;
      int accepts, results, lat, wait_cnt;
      accepts = 0; results = 0;
      for (int n = 0; n < 1000; n++) begin
         ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) ra = ~rb;
         if ($urandom_range(0, 7) == 0) ra = 32'hFFFF_FFFF - rb + 32'h1;
         full  = {1'b0, ra} + {1'b0, rb} + {32'h0, rc};
         gen   = {1'b0, ra} + {1'b0, rb};
         low   = {1'b0, ra[30:0]} + {1'b0, rb[30:0]} + {31'h0, rc};
         exp_p = &(ra ^ rb);
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         a = ra; b = rb; cin = rc; in_valid = 1'b1;
         wait_cnt = 0;
         while (in_ready !== 1'b1 && wait_cnt < 20) begin @(posedge clk); #1; wait_cnt++; end
         @(posedge clk); #1;
         if (wait_cnt < 20) accepts++;
         in_valid = 1'b0;
         lat = 0;
         while (out_valid !== 1'b1 && lat < 20) begin
            if ($urandom_range(0, 1) == 1) begin a = $urandom; in_valid = 1'b1; end
            @(posedge clk); #1; lat++;
            in_valid = 1'b0;
         end
         repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
         total++;
         if (out_valid !== 1'b1 || sum !== full[31:0]) begin
            bad++; $display("FAIL rnd%0d_sum: got %h valid=%b expected %h", n, sum, out_valid, full[31:0]);
         end
         total++;
         if ({cout, outG, outP} !== {full[32], gen[32], exp_p}) begin
            bad++; $display("FAIL rnd%0d_flags: got %b expected %b", n, {cout, outG, outP}, {full[32], gen[32], exp_p});
         end
`ifdef CLA_SEQ_OVF_EN
         total++;
         if (ovf !== (low[31] ^ full[32])) begin
            bad++; $display("FAIL rnd%0d_ovf: got %b expected %b", n, ovf, low[31] ^ full[32]);
         end
`endif
         out_ready = 1'b1;
         @(posedge clk); #1;
         if (out_valid === 1'b1 || in_ready === 1'b1) results++;
         out_ready = 1'b0;
         total++;
         if (out_valid !== 1'b0) begin bad++; $display("FAIL rnd%0d_dup: got out_valid=%b expected 0", n, out_valid); end
      end
      total++;
      if (accepts !== 1000 || results !== 1000) begin
         bad++; $display("FAIL rnd_count: got accepts=%0d results=%0d expected 1000/1000", accepts, results);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_vectors();
      test_backpressure();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
